// File: rtl/serial_pkg.sv
// Shared types and constants for the serial link pacing logic.
package serial_pkg;

  localparam int SERIAL_BYTE_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_STROBE,
    TX_GAP
  } tx_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Small synchronous FIFO with registered pointers and a synchronous flush.
// Pointers carry one extra bit so full and empty can be told apart.
module serial_tx_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = SERIAL_BYTE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_wr_ptr;
  logic [LW-1:0]    r_rd_ptr;
  logic [LW-1:0]    w_level;

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign o_level = w_level;
  assign o_full  = (w_level == LW'(DEPTH));
  assign o_empty = (w_level == '0);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx_pacer.sv
// Paces queued dot4x-domain bytes onto the CDC strobe toward the MCU link.
// Optional statistics counters are enabled by defining SERIAL_TX_STATS_EN.
module serial_tx_pacer
  import serial_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int SETUP_CYCLES = 3,
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 1024
) (
  input  logic                       clk_dot4x,
  input  logic                       rst_n,
  input  logic [SERIAL_BYTE_W-1:0]   in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [SERIAL_BYTE_W-1:0]   tx_data_4x,
  output logic                       tx_new_data_4x,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
`ifdef SERIAL_TX_STATS_EN
  ,
  output logic [15:0]                sent_count,
  output logic [7:0]                 drop_count
`endif
);

  localparam int MAX_CYC = max3(SETUP_CYCLES, HOLD_CYCLES, GAP_CYCLES);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  tx_state_t                r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [SERIAL_BYTE_W-1:0] r_tx_data;
  logic                     r_strobe;
  logic                     r_overflow;

  logic [SERIAL_BYTE_W-1:0] w_head;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_drop;
  logic                     w_cnt_zero;

  // A pop in the same cycle frees a slot, so a push at full is still taken.
  assign w_pop      = (r_state == TX_IDLE) && !w_empty && !flush;
  assign w_push     = in_valid && !flush && (!w_full || w_pop);
  assign w_drop     = in_valid && !flush && w_full && !w_pop;
  assign w_cnt_zero = (r_cnt == '0);

  serial_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SERIAL_BYTE_W)
  ) u_fifo (
    .clk     (clk_dot4x),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .i_flush (flush),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= TX_IDLE;
      r_cnt     <= '0;
      r_tx_data <= '0;
      r_strobe  <= 1'b0;
    end else if (flush) begin
      r_state  <= TX_IDLE;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (w_pop) begin
            r_tx_data <= w_head;
            r_state   <= TX_SETUP;
            r_cnt     <= CNT_W'(SETUP_CYCLES - 1);
          end
        end
        TX_SETUP: begin
          if (w_cnt_zero) begin
            r_state  <= TX_STROBE;
            r_cnt    <= CNT_W'(HOLD_CYCLES - 1);
            r_strobe <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        TX_STROBE: begin
          if (w_cnt_zero) begin
            r_state  <= TX_GAP;
            r_cnt    <= CNT_W'(GAP_CYCLES - 1);
            r_strobe <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        TX_GAP: begin
          if (w_cnt_zero) begin
            r_state <= TX_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state  <= TX_IDLE;
          r_strobe <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef SERIAL_TX_STATS_EN
  logic [15:0] r_sent_count;
  logic [7:0]  r_drop_count;

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      r_sent_count <= '0;
      r_drop_count <= '0;
    end else begin
      if (!flush && (r_state == TX_SETUP) && w_cnt_zero) begin
        r_sent_count <= r_sent_count + 16'd1;
      end
      if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign sent_count = r_sent_count;
  assign drop_count = r_drop_count;
`endif

  assign in_ready       = !w_full;
  assign tx_data_4x     = r_tx_data;
  assign tx_new_data_4x = r_strobe;
  assign overflow       = r_overflow;
  assign busy           = (r_state != TX_IDLE) || !w_empty;

endmodule

// File: tb/tb_serial_tx_pacer.sv
// Directed self-checking bench for serial_tx_pacer (default parameters).
// Build with SERIAL_TX_STATS_EN defined to also check the statistics counters.
module tb_serial_tx_pacer;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] tx_data_4x;
  logic       tx_new_data_4x;
  logic       busy;
  logic [3:0] level;
  logic       overflow;
`ifdef SERIAL_TX_STATS_EN
  logic [15:0] sent_count;
  logic [7:0]  drop_count;
`endif

  int errorCount = 0;
  int checkCount = 0;

  logic [7:0] riseData [64];
  int         riseTime [64];
  int         riseCount = 0;
  int         cycleNo   = 0;
  logic       prevStrobe = 1'b0;

  serial_tx_pacer #(
    .DEPTH        (8),
    .SETUP_CYCLES (3),
    .HOLD_CYCLES  (4),
    .GAP_CYCLES   (1024)
  ) dut (
    .clk_dot4x      (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .flush          (flush),
    .tx_data_4x     (tx_data_4x),
    .tx_new_data_4x (tx_new_data_4x),
    .busy           (busy),
    .level          (level),
    .overflow       (overflow)
`ifdef SERIAL_TX_STATS_EN
    ,
    .sent_count     (sent_count),
    .drop_count     (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every strobe rising edge with the byte presented at that moment.
  always @(negedge clk) begin
    if (tx_new_data_4x && !prevStrobe && riseCount < 64) begin
      riseData[riseCount] <= tx_data_4x;
      riseTime[riseCount] <= cycleNo;
      riseCount           <= riseCount + 1;
    end
    prevStrobe <= tx_new_data_4x;
    cycleNo    <= cycleNo + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic doFlush);
    in_valid = valid;
    in_data  = data;
    flush    = doFlush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic waitRises(input int target, input int maxCycles);
    int n;
    n = 0;
    while (riseCount < target && n < maxCycles) begin
      tick();
      n++;
    end
    if (riseCount < target) checkOutput("strobe wait timeout", riseCount, target);
  endtask

  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    while (busy && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput("return to idle", busy, 0);
  endtask

  initial begin
    int firstHigh;
    int lastHigh;
    int highCount;
    int base;

    applyStimulus(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #12;
    checkOutput("reset strobe", tx_new_data_4x, 0);
    checkOutput("reset data", tx_data_4x, 0);
    checkOutput("reset ready", in_ready, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset level", level, 0);
    checkOutput("reset overflow", overflow, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] reset asserted in the middle of a strobe");
    applyStimulus(1'b1, 8'h77, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (5) tick();
    checkOutput("t1 strobe before reset", tx_new_data_4x, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t1 strobe async clear", tx_new_data_4x, 0);
    checkOutput("t1 level", level, 0);
    checkOutput("t1 ready", in_ready, 1);
    checkOutput("t1 overflow", overflow, 0);
    checkOutput("t1 data", tx_data_4x, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] single byte latency and strobe width");
    resetDut();
    applyStimulus(1'b1, 8'hA5, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t2 level after push", level, 1);
    firstHigh = -1;
    lastHigh  = -1;
    highCount = 0;
    for (int e = 1; e <= 1031; e++) begin
      tick();
      if (e == 1) checkOutput("t2 data next cycle", tx_data_4x, 8'hA5);
      if (tx_new_data_4x) begin
        if (firstHigh < 0) firstHigh = e;
        lastHigh = e;
        highCount++;
      end
    end
    checkOutput("t2 first strobe cycle", firstHigh, 4);
    checkOutput("t2 last strobe cycle", lastHigh, 7);
    checkOutput("t2 strobe width", highCount, 4);
    checkOutput("t2 busy in gap", busy, 1);
    checkOutput("t2 data held", tx_data_4x, 8'hA5);
    tick();
    checkOutput("t2 idle after gap", busy, 0);

    $display("[TB] burst of eight bytes");
    resetDut();
    base = riseCount;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(i + 1), 1'b0);
      tick();
      checkOutput("t3 accepted", overflow, 0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t3 level after burst", level, 7);
    waitRises(base + 8, 8 * 1032 + 100);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t3 strobe order", riseData[base + i], i + 1);
    end
    for (int i = 0; i < 7; i++) begin
      checkOutput("t3 strobe spacing", riseTime[base + i + 1] - riseTime[base + i], 1032);
    end
    checkOutput("t3 level drained", level, 0);
    waitIdle(1100);

    $display("[TB] overflow on the tenth back-to-back push");
    resetDut();
    base = riseCount;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
      tick();
      if (i == 8) begin
        checkOutput("t4 full after nine", level, 8);
        checkOutput("t4 ready low", in_ready, 0);
        checkOutput("t4 no overflow yet", overflow, 0);
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t4 overflow set", overflow, 1);
    checkOutput("t4 level", level, 8);
`ifdef SERIAL_TX_STATS_EN
    checkOutput("t4 drop count", drop_count, 1);
`endif
    waitRises(base + 9, 9 * 1032 + 100);
    for (int i = 0; i < 9; i++) begin
      checkOutput("t4 strobe order", riseData[base + i], 8'h10 + i);
    end
    waitIdle(1100);
    repeat (10) tick();
    checkOutput("t4 no tenth byte", riseCount - base, 9);
    checkOutput("t4 overflow sticky", overflow, 1);

    $display("[TB] flush while strobing with bytes queued");
    base = riseCount;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(8'h30 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    checkOutput("t5 strobing", tx_new_data_4x, 1);
    checkOutput("t5 queued", level, 3);
    applyStimulus(1'b1, 8'hEE, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t5 strobe dropped", tx_new_data_4x, 0);
    checkOutput("t5 level cleared", level, 0);
    checkOutput("t5 busy", busy, 0);
    checkOutput("t5 overflow cleared", overflow, 0);
    checkOutput("t5 data retained", tx_data_4x, 8'h30);
    repeat (2000) tick();
    checkOutput("t5 no further strobes", riseCount - base, 1);
    checkOutput("t5 push discarded", level, 0);

    $display("[TB] push and pop together while full");
    resetDut();
    base = riseCount;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (1024) tick();
    checkOutput("t6 full before pop", level, 8);
    applyStimulus(1'b1, 8'h49, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t6 level unchanged", level, 8);
    checkOutput("t6 no overflow", overflow, 0);
    checkOutput("t6 next byte loaded", tx_data_4x, 8'h41);
    waitRises(base + 10, 9 * 1032 + 200);
    for (int i = 0; i < 10; i++) begin
      checkOutput("t6 strobe order", riseData[base + i], 8'h40 + i);
    end
    waitIdle(1100);
`ifdef SERIAL_TX_STATS_EN
    checkOutput("t6 sent count", sent_count, 10);
    checkOutput("t6 drop count", drop_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
